// File: rtl/point_sequencer.sv
// Point/serve sequencer for a two-player paddle game: serve countdown, rally
// speed-up, scoring with saturation and match-over detection.
module point_sequencer #(
    parameter int MaxScore   = 10,
    parameter int ServeDelay = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       valid,
    input  logic [2:0] Mode,
    input  logic       frame_tick,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       paddle_hit,
    output logic [8:0] score_1,
    output logic [8:0] score_2,
    output logic       ball_hold,
    output logic       ball_launch,
    output logic       serve_dir,
    output logic [2:0] ball_speed
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        RALLY,
        POINT,
        MATCH_OVER
    } state_t;

    localparam logic [8:0] ScoreMax  = 9'(MaxScore);
    localparam logic [7:0] DelayLoad = 8'(ServeDelay);

    state_t     state, state_d;
    logic [7:0] countdown, countdown_d;
    logic [1:0] hit_count, hit_count_d;
    logic [2:0] base_speed, base_speed_d;
    logic [8:0] score_1_d, score_2_d;
    logic       serve_dir_d;
    logic [2:0] ball_speed_d;
    logic       ball_hold_d;
    logic       ball_launch_d;

    function automatic logic [2:0] mode_speed(input logic [2:0] m);
        case (m)
            3'b001:  return 3'd2;
            3'b010:  return 3'd3;
            3'b011:  return 3'd4;
            3'b100:  return 3'd3;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [8:0] score_inc(input logic [8:0] s);
        return (s >= ScoreMax) ? ScoreMax : s + 9'd1;
    endfunction

    always_comb begin
        // NOTE: every next-value is defaulted to the current register first so
        // no path through the case leaves a signal unassigned (no latches).
        state_d      = state;
        countdown_d  = countdown;
        hit_count_d  = hit_count;
        base_speed_d = base_speed;
        score_1_d    = score_1;
        score_2_d    = score_2;
        serve_dir_d  = serve_dir;
        ball_speed_d = ball_speed;

        if (state != IDLE && !valid) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        state_d      = SERVE_WAIT;
                        score_1_d    = '0;
                        score_2_d    = '0;
                        countdown_d  = DelayLoad;
                        base_speed_d = mode_speed(Mode);
                        ball_speed_d = mode_speed(Mode);
                        hit_count_d  = '0;
                        serve_dir_d  = 1'b1;
                    end
                end
                SERVE_WAIT: begin
                    if (frame_tick) begin
                        if (countdown <= 8'd1) begin
                            state_d     = RALLY;
                            countdown_d = '0;
                        end else begin
                            countdown_d = countdown - 8'd1;
                        end
                    end
                end
                RALLY: begin
                    // A miss ends the rally and swallows any same-cycle paddle hit.
                    if (miss_left || miss_right) begin
                        state_d = POINT;
                        if (miss_left && !miss_right) begin
                            score_2_d   = score_inc(score_2);
                            serve_dir_d = 1'b0;
                        end else if (miss_right && !miss_left) begin
                            score_1_d   = score_inc(score_1);
                            serve_dir_d = 1'b1;
                        end
                    end else if (paddle_hit) begin
                        hit_count_d = hit_count + 2'd1;
                        if (hit_count == 2'd3 && ball_speed != 3'd7)
                            ball_speed_d = ball_speed + 3'd1;
                    end
                end
                POINT: begin
                    if (score_1 == ScoreMax || score_2 == ScoreMax) begin
                        state_d = MATCH_OVER;
                    end else begin
                        state_d      = SERVE_WAIT;
                        countdown_d  = DelayLoad;
                        ball_speed_d = base_speed;
                        hit_count_d  = '0;
                    end
                end
                MATCH_OVER: ;
                default: state_d = IDLE;
            endcase
        end

        ball_hold_d   = (state_d != RALLY);
        ball_launch_d = (state == SERVE_WAIT) && (state_d == RALLY);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values computed above.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            countdown   <= '0;
            hit_count   <= '0;
            base_speed  <= '0;
            score_1     <= '0;
            score_2     <= '0;
            serve_dir   <= 1'b1;
            ball_speed  <= '0;
            ball_hold   <= 1'b1;
            ball_launch <= 1'b0;
        end else begin
            state       <= state_d;
            countdown   <= countdown_d;
            hit_count   <= hit_count_d;
            base_speed  <= base_speed_d;
            score_1     <= score_1_d;
            score_2     <= score_2_d;
            serve_dir   <= serve_dir_d;
            ball_speed  <= ball_speed_d;
            ball_hold   <= ball_hold_d;
            ball_launch <= ball_launch_d;
        end
    end

endmodule

// File: tb/tb_point_sequencer.sv
// Self-checking bench for point_sequencer: directed scenarios followed by a
// randomized run, all compared against a behavioural match model.
module tb_point_sequencer;

    localparam int MaxScore   = 10;
    localparam int ServeDelay = 3;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_RALLY = 2;
    localparam int P_POINT = 3;
    localparam int P_OVER  = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       valid;
    logic [2:0] Mode;
    logic       frame_tick;
    logic       miss_left;
    logic       miss_right;
    logic       paddle_hit;
    logic [8:0] score_1;
    logic [8:0] score_2;
    logic       ball_hold;
    logic       ball_launch;
    logic       serve_dir;
    logic [2:0] ball_speed;

    int tests = 0;
    int fails = 0;

    // Model: match phase, scores, ticks left before serve, base speed and the
    // total number of paddle hits counted in the current rally.
    int m_phase, m_s1, m_s2, m_ticks, m_base, m_hits;
    bit m_dir, m_launch;

    point_sequencer #(.MaxScore(MaxScore), .ServeDelay(ServeDelay)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .valid      (valid),
        .Mode       (Mode),
        .frame_tick (frame_tick),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .paddle_hit (paddle_hit),
        .score_1    (score_1),
        .score_2    (score_2),
        .ball_hold  (ball_hold),
        .ball_launch(ball_launch),
        .serve_dir  (serve_dir),
        .ball_speed (ball_speed)
    );

    always #5 Clk = ~Clk;

    function automatic int base_of(input logic [2:0] m);
        if (m == 3'd1) return 2;
        if (m == 3'd2 || m == 3'd4) return 3;
        if (m == 3'd3) return 4;
        return 1;
    endfunction

    function automatic int m_speed();
        int s;
        s = m_base + m_hits / 4;
        return (s > 7) ? 7 : s;
    endfunction

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_s1     = 0;
        m_s2     = 0;
        m_ticks  = 0;
        m_base   = 0;
        m_hits   = 0;
        m_dir    = 1'b1;
        m_launch = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [2:0] md, input bit ft,
                              input bit ml, input bit mr, input bit ph);
        m_launch = 1'b0;
        if (m_phase != P_IDLE && !v) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: if (v) begin
                    m_phase = P_SERVE;
                    m_s1 = 0; m_s2 = 0;
                    m_ticks = ServeDelay;
                    m_base = base_of(md);
                    m_hits = 0;
                    m_dir = 1'b1;
                end
                P_SERVE: if (ft) begin
                    m_ticks--;
                    if (m_ticks == 0) begin
                        m_phase = P_RALLY;
                        m_launch = 1'b1;
                    end
                end
                P_RALLY: begin
                    if (ml || mr) begin
                        m_phase = P_POINT;
                        if (ml && !mr) begin
                            m_s2 = (m_s2 < MaxScore) ? m_s2 + 1 : MaxScore;
                            m_dir = 1'b0;
                        end else if (mr && !ml) begin
                            m_s1 = (m_s1 < MaxScore) ? m_s1 + 1 : MaxScore;
                            m_dir = 1'b1;
                        end
                    end else if (ph) begin
                        m_hits++;
                    end
                end
                P_POINT: begin
                    if (m_s1 == MaxScore || m_s2 == MaxScore) begin
                        m_phase = P_OVER;
                    end else begin
                        m_phase = P_SERVE;
                        m_ticks = ServeDelay;
                        m_hits = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/score_1"},     score_1,           9'(m_s1));
        check({tag, "/score_2"},     score_2,           9'(m_s2));
        check({tag, "/ball_hold"},   9'(ball_hold),     9'(m_phase != P_RALLY));
        check({tag, "/ball_launch"}, 9'(ball_launch),   9'(m_launch));
        check({tag, "/serve_dir"},   9'(serve_dir),     9'(m_dir));
        check({tag, "/ball_speed"},  9'(ball_speed),    9'(m_speed()));
    endtask

    // One clock: apply inputs, advance model at the edge, compare 1 ns later.
    task automatic cycle(input string tag, input bit v, input logic [2:0] md, input bit ft,
                         input bit ml, input bit mr, input bit ph);
        valid = v; Mode = md; frame_tick = ft;
        miss_left = ml; miss_right = mr; paddle_hit = ph;
        @(posedge Clk);
        model_step(v, md, ft, ml, mr, ph);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #1 Reset = 1'b0;
        #1 model_reset();
        check_all(tag);
        #1 Reset = 1'b1;
    endtask

    task automatic serve(input string tag, input logic [2:0] md);
        for (int i = 0; i < ServeDelay; i++) cycle(tag, 1, md, 1, 0, 0, 0);
    endtask

    initial begin
        Reset = 1'b0; valid = 0; Mode = 3'd0;
        frame_tick = 0; miss_left = 0; miss_right = 0; paddle_hit = 0;
        model_reset();
        #12;
        check_all("reset");
        Reset = 1'b1;

        cycle("idle", 0, 3'd2, 1, 1, 1, 1);
        cycle("idle", 0, 3'd2, 0, 0, 0, 0);

        // Medium serve: launch follows the third tick.
        cycle("start", 1, 3'd2, 0, 0, 0, 0);
        cycle("sw_tick1", 1, 3'd2, 1, 0, 0, 0);
        cycle("sw_gap", 1, 3'd2, 0, 1, 1, 1);
        cycle("sw_tick2", 1, 3'd2, 1, 0, 0, 0);
        cycle("sw_tick3", 1, 3'd2, 1, 0, 0, 0);
        check("launch_after_3rd_tick", 9'(ball_launch), 9'd1);
        check("speed_medium", 9'(ball_speed), 9'd3);
        cycle("rally", 1, 3'd5, 0, 0, 0, 0);

        // Scoring and serve direction.
        cycle("miss_right", 1, 3'd2, 0, 0, 1, 0);
        check("score_1_one", score_1, 9'd1);
        cycle("point_exit", 1, 3'd2, 0, 0, 0, 0);
        serve("serve2", 3'd2);
        cycle("miss_left", 1, 3'd2, 0, 1, 0, 0);
        check("serve_dir_left", 9'(serve_dir), 9'd0);
        cycle("point_exit2", 1, 3'd2, 0, 0, 0, 0);

        // Hard mode speed-up and restore after a point.
        cycle("drop", 0, 3'd3, 0, 0, 0, 0);
        cycle("start_hard", 1, 3'd3, 0, 0, 0, 0);
        serve("serve_hard", 3'd1);
        for (int i = 0; i < 8; i++) cycle("hits", 1, 3'd1, 0, 0, 0, 1);
        check("speed_after_8_hits", 9'(ball_speed), 9'd6);
        cycle("miss_after_hits", 1, 3'd1, 0, 1, 0, 0);
        cycle("point_restore", 1, 3'd1, 0, 0, 0, 0);
        check("speed_restored", 9'(ball_speed), 9'd4);

        // Simultaneous misses, then miss with a paddle hit on a wrapping count.
        serve("serve_dbl", 3'd3);
        cycle("double_miss", 1, 3'd3, 0, 1, 1, 0);
        cycle("dbl_point_exit", 1, 3'd3, 0, 0, 0, 0);
        serve("serve_mh", 3'd3);
        for (int i = 0; i < 3; i++) cycle("pre_hits", 1, 3'd3, 0, 0, 0, 1);
        cycle("miss_and_hit", 1, 3'd3, 0, 1, 0, 1);
        check("speed_no_wrap", 9'(ball_speed), 9'd4);
        cycle("mh_point_exit", 1, 3'd3, 0, 0, 0, 0);

        // Play player 1 up to the winning score.
        while (m_s1 < MaxScore) begin
            serve("serve_win", 3'd3);
            cycle("miss_right_win", 1, 3'd3, 0, 0, 1, 0);
            cycle("point_win", 1, 3'd3, 0, 0, 0, 0);
        end
        check("score_1_max", score_1, 9'(MaxScore));
        cycle("over_misses", 1, 3'd3, 1, 1, 0, 1);
        cycle("over_misses", 1, 3'd3, 0, 0, 1, 0);
        cycle("over_exit", 0, 3'd3, 0, 0, 0, 0);
        check("score_held_idle", score_1, 9'(MaxScore));

        // Reset mid-countdown with score_2 at 4.
        cycle("start_rst", 1, 3'd2, 0, 0, 0, 0);
        while (m_s2 < 4) begin
            serve("serve_rst", 3'd2);
            cycle("miss_left_rst", 1, 3'd2, 0, 1, 0, 0);
            cycle("point_rst", 1, 3'd2, 0, 0, 0, 0);
        end
        cycle("tick_rst", 1, 3'd2, 1, 0, 0, 0);
        async_reset("async_reset");
        cycle("post_reset_idle", 0, 3'd2, 1, 0, 0, 0);

        // Randomized play.
        for (int n = 0; n < 3000; n++) begin
            bit v, ft, ml, mr, ph;
            logic [2:0] md;
            v  = ($urandom_range(0, 99) != 0);
            md = 3'($urandom_range(0, 7));
            ft = ($urandom_range(0, 1) == 1);
            ml = ($urandom_range(0, 9) == 0);
            mr = ($urandom_range(0, 9) == 0);
            ph = ($urandom_range(0, 2) == 0);
            cycle("random", v, md, ft, ml, mr, ph);
            if ($urandom_range(0, 499) == 0) async_reset("random_reset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
